alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the 64-bit single-cycle ALU. Width is generic, shift/rotate amounts cover the full operand width, and status flags are produced. Multiply runs as a multi-cycle iterative operation instead of a single-cycle `*`. Sits between the operand-fetch stage and writeback, with valid/ready on both sides so back-pressure from writeback stalls it cleanly.

## Interface
- `WIDTH`, default 64: operand/result width; power of two, ≥8.
- `MUL_STEP`, default 4: multiplier bits retired per cycle; must divide `WIDTH`.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand/op presented.
- `in_ready` out 1: block can accept.
- `a`, `b` in `WIDTH`: operands.
- `op` in 4: opcode (see `alu_pkg::op_e`).
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `result` out `WIDTH`: result.
- `zero` out 1: result == 0.
- `carry` out 1: carry/borrow/unsigned overflow; op-dependent.
- `ovf` out 1: signed overflow (ADD/SUB only, else 0).
- `err` out 1: illegal opcode.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL (low `WIDTH` bits), 3 AND, 4 OR, 5 XOR, 6 NOT a, 7 SHL, 8 SHR (logical), 9 ROR, A ROL, B SRA, C SLT (signed, result 0/1), D SLTU, E/F illegal.
- Shift/rotate amount = `b[$clog2(WIDTH)-1:0]`. Amount 0 returns `a` unchanged. A rotate by 0 must not produce an out-of-range shift of `WIDTH`.
- `carry`:
  - ADD: bit `WIDTH` of the sum.
  - SUB: borrow (a < b unsigned).
  - MUL: upper half of the full product ≠ 0.
  - All other ops: 0.
- `ovf`: standard two's-complement rule for ADD/SUB.
- Illegal op: result 0, `err`=1, `zero`=1. Completes in single-cycle timing.
- FSM states:
  - IDLE: no result held, `in_ready`=1. On accept: non-MUL → DONE; MUL → BUSY, load multiplicand/multiplier/accumulator, counter=`WIDTH/MUL_STEP`.
  - BUSY: each cycle adds `MUL_STEP` partial products and decrements the counter. At counter 1 → DONE. `in_ready`=0.
  - DONE: `out_valid`=1, outputs stable. On `out_ready`: if `in_valid` also accepted → DONE/BUSY per new op, else → IDLE.
- `in_ready` = IDLE || (DONE && `out_ready`). Back-to-back single-cycle ops sustain 1 op/cycle.
- Outputs are registered. `result`/flags change only on transition into DONE.

## Timing
- Reset (async assert, sync deassert assumed upstream): state IDLE. `in_ready`=1, `out_valid`=0, `result`=0, all flags 0.
- Non-MUL: accepted at edge N → `out_valid` high after edge N+1.
- MUL: accepted at edge N → `out_valid` high after edge N+`WIDTH/MUL_STEP`+1 (default 17).
- `out_valid` with `out_ready`=0: result and flags held indefinitely, no new accept.
- Accept and drain in the same cycle: old result retired, new op taken, no bubble for non-MUL.
- Reset mid-MUL: BUSY aborted, no `out_valid` emitted.
- `in_valid` may drop without acceptance. Inputs are sampled only on accept and need not be held afterward.

## Structure
- `alu_pkg`: `op_e` enum (4-bit), `state_e` {IDLE, BUSY, DONE}, `OP_ILLEGAL_MIN`=4'hE.
- Sub-module `alu_mul_iter`: iterative shift-add multiplier.
  - Parameters: `WIDTH`, `MUL_STEP`.
  - Signals: start/done, full 2·`WIDTH` product.
  - The FSM lives in the top level; the sub-module holds only the datapath and counter.
- Combinational single-cycle datapath stays in top level as one case on `op`.

## Test plan
- ADD `a`=64'hFFFF_FFFF_FFFF_FFFF, `b`=1 → `result`=0, `zero`=1, `carry`=1, `ovf`=0, `out_valid` one cycle after accept.
- ROR `a`=64'h1, `b`=63 → 64'h2. ROR `b`=0 → `a`. SHL `b`=64 → amount 0 → `a`.
- MUL `a`=64'h1_0000_0000, `b`=64'h1_0000_0000 → `result`=0, `carry`=1. `out_valid` exactly 17 cycles after accept; `in_ready`=0 throughout BUSY.
- Back-pressure: hold `out_ready`=0 for 5 cycles after SUB 5−7 → `result`=64'hFFFF_FFFF_FFFF_FFFE, `carry`=1, stable. Then stream 4 ADDs with `out_ready`=1 → 4 results on 4 consecutive cycles.
- `op`=4'hF, `a`=`b`=3 → `result`=0, `err`=1, `zero`=1.
- Assert `rst_n`=0 at cycle 6 of a MUL → all outputs reset values. After release, IDLE with `in_ready`=1 and no stale `out_valid`. Repeat the full suite with `WIDTH`=16, `MUL_STEP`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential ALU.
//   op_e           - 4-bit opcode set (0x0..0xD legal, 0xE/0xF illegal)
//   state_e        - control FSM states
//   OP_ILLEGAL_MIN - first opcode value that is rejected with err=1
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_ROR  = 4'h9,
        OP_ROL  = 4'hA,
        OP_SRA  = 4'hB,
        OP_SLT  = 4'hC,
        OP_SLTU = 4'hD
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] OP_ILLEGAL_MIN = 4'hE;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake bundle between operand fetch, the ALU and writeback.
//   Upstream  : in_valid, in_ready, a, b, op
//   Downstream: out_valid, out_ready, result, zero, carry, ovf, err
//   master modport = surrounding pipeline, slave modport = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, carry, ovf, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf, err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin (WIDTH/MUL_STEP steps follow)
//   a, b       : multiplicand / multiplier, sampled on start
//   done       : high during the final step cycle
//   product    : full 2*WIDTH product value after the current step;
//                valid as the final answer while done is high
// Sequencing is owned by the caller; this block only steps while its
// counter is non-zero.
module alu_mul_iter #(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] partial [MUL_STEP];

    // One partial product per multiplier bit retired this cycle.
    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_partial
        assign partial[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end

    always_comb begin
        acc_next = acc_reg;
        for (int j = 0; j < MUL_STEP; j++) begin
            acc_next = acc_next + partial[j];
        end
    end

    assign done    = (cnt_reg == CNT_W'(1));
    assign product = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= CNT_W'(STEPS);
        end else if (cnt_reg != '0) begin
            mcand_reg  <= mcand_reg << MUL_STEP;
            mplier_reg <= mplier_reg >> MUL_STEP;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_reg - CNT_W'(1);
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith ops and an
// iterative multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_if slave (in_valid/in_ready/a/b/op upstream,
//                out_valid/out_ready/result/zero/carry/ovf/err downstream)
// Results and flags are registered and only change when entering DONE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    state_e           state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             err_reg;

    logic             in_ready;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] comb_result;
    logic             comb_carry;
    logic             comb_ovf;
    logic             comb_err;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SH_W-1:0]  shamt;
    logic [SH_W-1:0]  shamt_neg;

    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign is_mul   = (bus.op == OP_MUL);

    assign shamt     = bus.b[SH_W-1:0];
    // (WIDTH - shamt) mod WIDTH: 0 for shamt 0, so rotates never shift by WIDTH.
    assign shamt_neg = SH_W'(0) - shamt;

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        comb_result = '0;
        comb_carry  = 1'b0;
        comb_ovf    = 1'b0;
        comb_err    = 1'b0;
        sum_ext     = {1'b0, bus.a} + {1'b0, bus.b};
        diff_ext    = {1'b0, bus.a} - {1'b0, bus.b};
        case (bus.op)
            OP_ADD: begin
                comb_result = sum_ext[WIDTH-1:0];
                comb_carry  = sum_ext[WIDTH];
                comb_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                              (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                comb_result = diff_ext[WIDTH-1:0];
                comb_carry  = diff_ext[WIDTH];   // borrow out == a < b unsigned
                comb_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                              (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MUL:  comb_result = '0;           // handled by the iterative path
            OP_AND:  comb_result = bus.a & bus.b;
            OP_OR:   comb_result = bus.a | bus.b;
            OP_XOR:  comb_result = bus.a ^ bus.b;
            OP_NOT:  comb_result = ~bus.a;
            OP_SHL:  comb_result = bus.a << shamt;
            OP_SHR:  comb_result = bus.a >> shamt;
            OP_ROR:  comb_result = (bus.a >> shamt) | (bus.a << shamt_neg);
            OP_ROL:  comb_result = (bus.a << shamt) | (bus.a >> shamt_neg);
            OP_SRA:  comb_result = $signed(bus.a) >>> shamt;
            OP_SLT:  comb_result = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SLTU: comb_result = WIDTH'(bus.a < bus.b);
            default: comb_err    = 1'b1;         // opcodes >= OP_ILLEGAL_MIN
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE and DONE-with-drain: the old result retires
            // on this edge and the new op is taken without a bubble.
            if (is_mul) begin
                state_reg     <= BUSY;
                out_valid_reg <= 1'b0;
            end else begin
                state_reg     <= DONE;
                out_valid_reg <= 1'b1;
                result_reg    <= comb_result;
                zero_reg      <= (comb_result == '0);
                carry_reg     <= comb_carry;
                ovf_reg       <= comb_ovf;
                err_reg       <= comb_err;
            end
        end else begin
            case (state_reg)
                BUSY: begin
                    if (mul_done) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= mul_product[WIDTH-1:0];
                        zero_reg      <= (mul_product[WIDTH-1:0] == '0);
                        carry_reg     <= |mul_product[2*WIDTH-1:WIDTH];
                        ovf_reg       <= 1'b0;
                        err_reg       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.carry     = carry_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.err       = err_reg;
endmodule
